// File: rtl/md_audio_i2s_if.sv
// Stereo sample input and I2S output bundle for md_audio_i2s.
// The slave side is the audio stage itself; the master side feeds samples and observes the stream.
interface md_audio_i2s_if;
  logic [15:0] A_L;
  logic [15:0] A_R;
  logic        I2S_BCLK;
  logic        I2S_LRCK;
  logic        I2S_SD;
  logic        sample_strobe;

  modport master (
    output A_L,
    output A_R,
    input  I2S_BCLK,
    input  I2S_LRCK,
    input  I2S_SD,
    input  sample_strobe
  );

  modport slave (
    input  A_L,
    input  A_R,
    output I2S_BCLK,
    output I2S_LRCK,
    output I2S_SD,
    output sample_strobe
  );
endinterface

// File: rtl/md_audio_i2s.sv
// Decimates MCLK-rate stereo samples to one pair per frame and serialises them as I2S (16-bit in 32-bit slots).
// Define MD_AUDIO_DECIM_EN for box-car averaging over the frame; otherwise the frame event point-samples the inputs.
module md_audio_i2s #(
  parameter int unsigned BCLK_DIV = 9
) (
  input  logic          MCLK,
  input  logic          ext_reset,
  md_audio_i2s_if.slave bus
);

  logic [7:0]  dcnt;
  logic [5:0]  bcnt;
  logic        bclk;
  logic        lrck;
  logic        sd;
  logic        strobe;
  logic [15:0] l_word;
  logic [15:0] r_word;

  logic        div_end;
  logic        rise_ev;
  logic        fall_ev;
  logic        frame_ev;
  logic [5:0]  bcnt_next;
  logic [4:0]  slot;
  logic        sd_next;
  logic [15:0] l_latch;
  logic [15:0] r_latch;

  assign div_end   = (dcnt == 8'(BCLK_DIV - 1));
  assign rise_ev   = div_end && !bclk;
  assign fall_ev   = div_end && bclk;
  assign bcnt_next = bcnt + 6'd1;
  assign frame_ev  = fall_ev && (bcnt_next == '0);
  assign slot      = bcnt_next[4:0];

  // Slot positions 1..16 carry the word MSB first; position 0 gives the one-bit I2S delay.
  always_comb begin
    sd_next = 1'b0;
    if (slot >= 5'd1 && slot <= 5'd16) begin
      sd_next = bcnt_next[5] ? r_word[4'(5'd16 - slot)] : l_word[4'(5'd16 - slot)];
    end
  end

`ifdef MD_AUDIO_DECIM_EN
  logic signed [21:0] acc_l;
  logic signed [21:0] acc_r;

  // Rise and fall events never coincide, so clearing on the frame event never drops an add.
  always_ff @(posedge MCLK) begin
    if (ext_reset) begin
      acc_l <= '0;
      acc_r <= '0;
    end else if (frame_ev) begin
      acc_l <= '0;
      acc_r <= '0;
    end else if (rise_ev) begin
      acc_l <= acc_l + {{6{bus.A_L[15]}}, bus.A_L};
      acc_r <= acc_r + {{6{bus.A_R[15]}}, bus.A_R};
    end
  end

  assign l_latch = 16'(acc_l >>> 6);
  assign r_latch = 16'(acc_r >>> 6);
`else
  assign l_latch = bus.A_L;
  assign r_latch = bus.A_R;
`endif

  always_ff @(posedge MCLK) begin
    if (ext_reset) begin
      dcnt   <= '0;
      bcnt   <= '0;
      bclk   <= 1'b0;
      lrck   <= 1'b0;
      sd     <= 1'b0;
      strobe <= 1'b0;
      l_word <= '0;
      r_word <= '0;
    end else begin
      strobe <= 1'b0;
      if (div_end) begin
        dcnt <= '0;
        bclk <= ~bclk;
      end else begin
        dcnt <= dcnt + 8'd1;
      end
      if (fall_ev) begin
        bcnt <= bcnt_next;
        lrck <= bcnt_next[5];
        sd   <= sd_next;
        if (frame_ev) begin
          l_word <= l_latch;
          r_word <= r_latch;
          strobe <= 1'b1;
        end
      end
    end
  end

  assign bus.I2S_BCLK      = bclk;
  assign bus.I2S_LRCK      = lrck;
  assign bus.I2S_SD        = sd;
  assign bus.sample_strobe = strobe;

endmodule

// File: tb/tb_md_audio_i2s.sv
// Self-checking bench for md_audio_i2s: scoreboarded frame contents at BCLK_DIV=9, clock geometry at BCLK_DIV=2.
// Expectations follow MD_AUDIO_DECIM_EN when the bench is built with it.
module tb_md_audio_i2s;
  localparam int unsigned DIV   = 9;
  localparam int unsigned FRAME = 128 * DIV;
`ifdef MD_AUDIO_DECIM_EN
  localparam bit DECIM = 1'b1;
`else
  localparam bit DECIM = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  pair_t       sb[$];

  md_audio_i2s_if b9 ();
  md_audio_i2s_if b2 ();

  md_audio_i2s #(.BCLK_DIV(DIV)) dut9 (.MCLK(clk), .ext_reset(rst), .bus(b9));
  md_audio_i2s #(.BCLK_DIV(2))   dut2 (.MCLK(clk), .ext_reset(rst), .bus(b2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input string tag, input int unsigned limit, output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b9.sample_strobe && n < limit);
    chk(tag, b9.sample_strobe, 1'b1);
  endtask

  task automatic next_frame(input logic [15:0] l, input logic [15:0] r,
                            input logic [15:0] el, input logic [15:0] er);
    int unsigned n;
    b9.A_L = l;
    b9.A_R = r;
    sb.push_back({el, er});
    wait_strobe("frame_strobe", FRAME + 50, n);
  endtask

  // Frame monitor: slot k of a frame is sampled on the k-th BCLK rise after the frame start.
  logic        pb, plr, psd, active, have_last;
  int unsigned nrise, last_strobe;
  logic [63:0] sdbits, lrbits;
  logic [15:0] wl, wr;
  pair_t       cur;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      pb = b9.I2S_BCLK; plr = b9.I2S_LRCK; psd = b9.I2S_SD;
      nrise = 0; active = 1'b1; cur = '0; have_last = 1'b0;
      sdbits = '0; lrbits = '0;
    end else begin
      if (b9.I2S_SD !== psd || b9.I2S_LRCK !== plr)
        chk("edge_align", {pb, b9.I2S_BCLK}, 2'b10);
      if (!pb && b9.I2S_BCLK) begin
        if (nrise < 64) begin
          sdbits[nrise] = b9.I2S_SD;
          lrbits[nrise] = b9.I2S_LRCK;
        end
        nrise++;
      end
      if (b9.sample_strobe) begin
        if (have_last) chk("strobe_gap", cyc - last_strobe, FRAME);
        last_strobe = cyc;
        have_last   = 1'b1;
        if (active) begin
          for (int i = 0; i < 16; i++) begin
            wl[15-i] = sdbits[1+i];
            wr[15-i] = sdbits[33+i];
          end
          chk("frame_len", nrise, 64);
          chk("word_l", wl, cur.l);
          chk("word_r", wr, cur.r);
          chk("pad_zero", sdbits & ~64'h0001_FFFE_0001_FFFE, 64'h0);
          chk("lrck_slot", lrbits, 64'hFFFF_FFFF_0000_0000);
        end
        if (sb.size() > 0) begin
          cur    = sb.pop_front();
          active = 1'b1;
        end else begin
          active = 1'b0;
        end
        nrise = 0; sdbits = '0; lrbits = '0;
      end
      pb = b9.I2S_BCLK; plr = b9.I2S_LRCK; psd = b9.I2S_SD;
    end
  end

  // Geometry monitor for BCLK_DIV=2.
  logic        p2b, p2l, have_rise, have_lr;
  int unsigned last_rise, last_lr, fcnt;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      p2b = b2.I2S_BCLK; p2l = b2.I2S_LRCK;
      have_rise = 1'b0; have_lr = 1'b0; fcnt = 0;
    end else begin
      if (!p2b && b2.I2S_BCLK) begin
        if (have_rise) chk("bclk2_period", cyc - last_rise, 4);
        last_rise = cyc; have_rise = 1'b1;
      end
      if (!p2l && b2.I2S_LRCK) begin
        if (have_lr) chk("lrck2_period", cyc - last_lr, 256);
        last_lr = cyc; have_lr = 1'b1;
      end
      if (p2b && !b2.I2S_BCLK) begin
        fcnt = (fcnt + 1) % 64;
        chk("strobe2_pos", b2.sample_strobe, fcnt == 0);
        chk("lrck2_bcnt", b2.I2S_LRCK, fcnt >= 32);
      end
      p2b = b2.I2S_BCLK; p2l = b2.I2S_LRCK;
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned m;
    rst = 1'b1;
    b9.A_L = 16'h1234; b9.A_R = 16'hFEDC;
    b2.A_L = '0;       b2.A_R = '0;
    sb.push_back({16'h1234, 16'hFEDC});
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_out", {b9.I2S_BCLK, b9.I2S_LRCK, b9.I2S_SD, b9.sample_strobe}, 4'b0000);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("post_reset_quiet", {b9.I2S_BCLK, b9.I2S_LRCK, b9.I2S_SD, b9.sample_strobe}, 4'b0000);
    end
    @(negedge clk);
    chk("bclk_first_rise", b9.I2S_BCLK, 1'b1);
    wait_strobe("first_strobe", FRAME + 50, m);
    chk("first_strobe_latency", 9 + m, FRAME);

    next_frame(16'h1234, 16'hFEDC, 16'h1234, 16'hFEDC);
    next_frame(16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF);
    next_frame(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000);
    next_frame(16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF);

    // Input present for the first 32 rise events only; the rest of the frame is zero.
    b9.A_L = 16'h0100; b9.A_R = 16'hFFFF;
    sb.push_back(DECIM ? {16'h0080, 16'hFFFF} : {16'h0000, 16'h0000});
    repeat (64 * DIV) @(negedge clk);
    b9.A_L = 16'h0000; b9.A_R = 16'h0000;
    wait_strobe("half_strobe", FRAME, m);

    // A_L only takes its new value on the frame-event edge itself.
    b9.A_L = 16'h0000; b9.A_R = 16'h1111;
    sb.push_back(DECIM ? {16'h0000, 16'h1111} : {16'h5555, 16'h1111});
    repeat (FRAME - 1) @(negedge clk);
    b9.A_L = 16'h5555;
    wait_strobe("point_strobe", 10, m);
    chk("point_timing", m, 1);
    next_frame(16'h5555, 16'h1111, 16'h5555, 16'h1111);

    // Reset while bcnt is 20.
    b9.A_L = 16'h2468; b9.A_R = 16'h1357;
    sb.push_back({16'h2468, 16'h1357});
    repeat (40 * DIV + 5) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midreset_out", {b9.I2S_BCLK, b9.I2S_LRCK, b9.I2S_SD, b9.sample_strobe}, 4'b0000);
    @(negedge clk);
    chk("midreset_hold", {b9.I2S_BCLK, b9.I2S_LRCK, b9.I2S_SD, b9.sample_strobe}, 4'b0000);
    @(negedge clk);
    sb.push_back({16'h2468, 16'h1357});
    rst = 1'b0;
    wait_strobe("post_midreset", FRAME + 50, m);
    chk("midreset_latency", m, FRAME);
    next_frame(16'h2468, 16'h1357, 16'h2468, 16'h1357);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/md_audio_i2s.md
# md_audio_i2s

Audio output stage directly downstream of the board-level mix. It consumes the 16-bit signed stereo samples `A_L`/`A_R` produced at the `MCLK` rate. It box-car decimates them to one sample pair per I2S frame and serialises the result as a standard I2S stream (BCLK, LRCK, SD) for an external DAC or HDMI audio encoder. All logic runs on `MCLK`; the I2S clocks are generated internally as registered outputs.

## Interface
- `BCLK_DIV`, default 9, number of `MCLK` cycles per BCLK half-period; legal range is 1..255. With the default, frame rate is 53.693 MHz / 1152 ≈ 46.6 kHz.
- `MCLK`  in  1  system clock; the only clock in the block.
- `ext_reset`  in  1  reset. It is synchronous and active-high.
- `A_L`  in  16  left sample, two's complement, sampled every `MCLK`.
- `A_R`  in  16  right sample, two's complement.
- `I2S_BCLK`  out  1  bit clock, registered.
- `I2S_LRCK`  out  1  word select: 0 = left, 1 = right; registered.
- `I2S_SD`  out  1  serial data, MSB first; registered.
- `sample_strobe`  out  1  one-`MCLK` pulse when a new output pair is latched.

## Operation
- **Divider.** `dcnt` counts 0..BCLK_DIV-1.
  - At BCLK_DIV-1, `dcnt` goes to 0 and `I2S_BCLK` toggles; otherwise `dcnt` increments.
  - A *rise event* is that cycle with `I2S_BCLK`=0.
  - A *fall event* is that cycle with `I2S_BCLK`=1.
- **Bit counter.** `bcnt` is 6 bits and increments mod 64 on each fall event.
  - `I2S_LRCK` is loaded with `bcnt_next[5]` on the fall event.
- **Serial data.** On each fall event, `I2S_SD` is loaded from the slot position `p = bcnt_next[4:0]`.
  - For p in 1..16, `I2S_SD` takes bit (16-p) of the channel word: `L_word` when `bcnt_next[5]`=0, `R_word` otherwise.
  - Otherwise `I2S_SD` is 0.
  - This gives the standard I2S one-bit delay after the LRCK edge, with the 16-bit word left-aligned in a 32-bit slot and zero padding.
- **Frame event.** This is the fall event where `bcnt_next`==0. On it:
  - `L_word`/`R_word` are latched;
  - the accumulators are cleared;
  - `sample_strobe`=1 for exactly that cycle.
  - The latched words are used for the whole following frame.
- **Accumulation.** On each rise event, `acc_L += sext22(A_L)` and `acc_R += sext22(A_R)`.
  - Accumulators are 22-bit signed.
  - Exactly 64 rise events fall between consecutive frame events, so there is no overflow.
- **Latch arithmetic.** `L_word = acc_L[21:6]` and `R_word = acc_R[21:6]`, i.e. an arithmetic shift right by 6, truncating toward −∞.
  - The latch uses the accumulator value before any add. Rise and fall events are mutually exclusive, so no add coincides with the latch.
- **Reset state.** Reset clears `dcnt`, `bcnt`, both accumulators and both words.
- **Frame timing.** The first frame after reset ends at the first `bcnt` wrap.

## Timing
- **Reset values.** `I2S_BCLK`=0, `I2S_LRCK`=0, `I2S_SD`=0, `sample_strobe`=0. All are held while `ext_reset`=1 and take effect on the first edge with reset high.
- **BCLK.** The first toggle (to 1) happens at the BCLK_DIV-th `MCLK` edge after reset deasserts. BCLK period is 2·BCLK_DIV `MCLK` cycles; LRCK period is 128·BCLK_DIV.
- **Output edges.** `I2S_SD` and `I2S_LRCK` change only in the same cycle `I2S_BCLK` falls. They are stable across the BCLK rising edge.
- **Latency.** A sample contributes to the frame latched at the next frame event. Its MSB appears on `I2S_SD` one BCLK period after that frame event.
- **Reset mid-frame.**
  - The frame in progress is discarded.
  - The output words become 0.
  - Serialisation restarts at `bcnt`=0.
  - No `sample_strobe` pulse occurs during reset.
- **Extreme inputs.** Constant inputs of 16'h8000 and 16'h7FFF reproduce exactly; intermediate overflow is impossible.

## Configuration
- `MD_AUDIO_DECIM_EN`
  - **Defined:** box-car averaging as described, with the 22-bit accumulators.
  - **Undefined:** the accumulators are not built. At the frame event, `L_word`/`R_word` are loaded directly with `A_L`/`A_R` present on that cycle (point sampling). All other timing is identical.

## Test plan
- **Reset.** Hold `ext_reset` for 4 cycles, release; BCLK_DIV=9.
  - Outputs stay 0 for 8 cycles after release.
  - `I2S_BCLK` goes to 1 on the 9th edge.
  - `sample_strobe` first pulses 1152 cycles after release.
- **Constant input.** `A_L`=16'h1234, `A_R`=16'hFEDC.
  - From the second frame on: LRCK-low slot bits 1..16 = 0x1234, LRCK-high slot bits 1..16 = 0xFEDC, all other slot bits 0.
  - Strobe spacing is exactly 1152 `MCLK` cycles.
- **Clock geometry.** BCLK_DIV=2: BCLK period is 4 cycles, LRCK period 256 cycles; LRCK is high for `bcnt` 32..63.
- **Averaging, with macro.**
  - `A_L`=16'h0100 for the first 32 rise events of a frame, then 0 for the next 32 → latched `L_word`=16'h0080.
  - Constant 16'h8000 → 16'h8000.
- **Point sampling, without macro.** `A_L` changes from 16'h0000 to 16'h5555 on the frame-event cycle → latched word is 16'h5555.
- **Reset mid-frame.** Assert `ext_reset` at `bcnt`=20.
  - All outputs are 0 the following cycle.
  - After release, the first frame serialises zeros.
  - The next strobe comes 1152 cycles after release.
